// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with an
// NZCV flag register, B.cond evaluation and a bounded data-memory handshake.
module legv8_multicycle_ctrl #(
  parameter int ALUOP_W     = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [10:0]        i_opCode,
  input  logic [3:0]         i_bCond,
  input  logic               i_aluZ,
  input  logic               i_aluN,
  input  logic               i_aluC,
  input  logic               i_aluV,
  input  logic               i_memAck,
  output logic               o_irWr,
  output logic               o_pcWr,
  output logic               o_reg2Sel,
  output logic               o_rfWr,
  output logic [1:0]         o_SEU,
  output logic               o_ALUSrcB,
  output logic [ALUOP_W-1:0] o_ALUOp,
  output logic               o_memRd,
  output logic               o_memWr,
  output logic [1:0]         o_PCSrc,
  output logic               o_wrDataSel,
  output logic [3:0]         o_flags,
  output logic               o_illegal,
  output logic               o_memErr,
  output logic [2:0]         o_dbgState
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [4:0] C_ADD   = 5'd0;
  localparam logic [4:0] C_ADDS  = 5'd1;
  localparam logic [4:0] C_SUB   = 5'd2;
  localparam logic [4:0] C_SUBS  = 5'd3;
  localparam logic [4:0] C_AND   = 5'd4;
  localparam logic [4:0] C_ORR   = 5'd5;
  localparam logic [4:0] C_LSL   = 5'd6;
  localparam logic [4:0] C_LSR   = 5'd7;
  localparam logic [4:0] C_BR    = 5'd8;
  localparam logic [4:0] C_ADDI  = 5'd9;
  localparam logic [4:0] C_ADDIS = 5'd10;
  localparam logic [4:0] C_SUBI  = 5'd11;
  localparam logic [4:0] C_SUBIS = 5'd12;
  localparam logic [4:0] C_ANDI  = 5'd13;
  localparam logic [4:0] C_ORRI  = 5'd14;
  localparam logic [4:0] C_LDUR  = 5'd15;
  localparam logic [4:0] C_STUR  = 5'd16;
  localparam logic [4:0] C_B     = 5'd17;
  localparam logic [4:0] C_BL    = 5'd18;
  localparam logic [4:0] C_CBZ   = 5'd19;
  localparam logic [4:0] C_CBNZ  = 5'd20;
  localparam logic [4:0] C_BCOND = 5'd21;
  localparam logic [4:0] C_ILL   = 5'd31;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_ORR   = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_LSL   = ALUOP_W'(6);
  localparam logic [ALUOP_W-1:0] ALU_LSR   = ALUOP_W'(7);
  localparam logic [ALUOP_W-1:0] ALU_PASSB = ALUOP_W'(8);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  // I-format opcodes are 10 bits wide, so bit 0 of the 11-bit field is a don't-care.
  function automatic logic [4:0] classify(input logic [10:0] op);
    logic [4:0] cls;
    casez (op)
      11'b10001011000: cls = C_ADD;
      11'b10101011000: cls = C_ADDS;
      11'b11001011000: cls = C_SUB;
      11'b11101011000: cls = C_SUBS;
      11'b10001010000: cls = C_AND;
      11'b10101010000: cls = C_ORR;
      11'b11010011011: cls = C_LSL;
      11'b11010011010: cls = C_LSR;
      11'b11010110000: cls = C_BR;
      11'b1001000100?: cls = C_ADDI;
      11'b1011000100?: cls = C_ADDIS;
      11'b1101000100?: cls = C_SUBI;
      11'b1111000100?: cls = C_SUBIS;
      11'b1001001000?: cls = C_ANDI;
      11'b1011001000?: cls = C_ORRI;
      11'b11111000010: cls = C_LDUR;
      11'b11111000000: cls = C_STUR;
      11'b000101?????: cls = C_B;
      11'b100101?????: cls = C_BL;
      11'b10110100???: cls = C_CBZ;
      11'b10110101???: cls = C_CBNZ;
      11'b01010100???: cls = C_BCOND;
      default:         cls = C_ILL;
    endcase
    return cls;
  endfunction

  function automatic logic cond_true(input logic [3:0] nzcv, input logic [3:0] code);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (code)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = c;
      4'h3:    r = !c;
      4'h4:    r = n;
      4'h5:    r = !n;
      4'h6:    r = v;
      4'h7:    r = !v;
      4'h8:    r = c && !z;
      4'h9:    r = !(c && !z);
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = !z && (n == v);
      4'hD:    r = !(!z && (n == v));
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  logic [2:0]      state_q, state_d;
  logic [10:0]     op_q, op_d;
  logic [3:0]      cond_q, cond_d;
  logic [3:0]      nzcv_q, nzcv_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  logic [4:0] cls;
  logic [4:0] dec_cls;
  logic       is_alu;
  logic       sets_flags;

  logic               ir_wr, pc_wr, reg2_sel, rf_wr, alu_src_b;
  logic [1:0]         seu, pc_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               mem_rd, mem_wr, wr_data_sel, illegal, mem_err;

  assign cls     = classify(op_q);
  assign dec_cls = classify(i_opCode);

  assign is_alu = (cls <= C_LSR) || ((cls >= C_ADDI) && (cls <= C_ORRI));
  assign sets_flags = (cls == C_ADDS) || (cls == C_SUBS) ||
                      (cls == C_ADDIS) || (cls == C_SUBIS);

  // Memory handshake: o_memRd/o_memWr stay high every MEM cycle until a cycle
  // in which i_memAck is sampled high; that cycle completes the access. If
  // MEM_TIMEOUT cycles pass without ack, the request drops and o_memErr pulses.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cond_d      = cond_q;
    nzcv_d      = nzcv_q;
    to_cnt_d    = to_cnt_q;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    reg2_sel    = 1'b0;
    rf_wr       = 1'b0;
    seu         = 2'd0;
    alu_src_b   = 1'b0;
    alu_op      = ALU_ADD;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    pc_src      = 2'd0;
    wr_data_sel = 1'b0;
    illegal     = 1'b0;
    mem_err     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        state_d = S_DECODE;
      end

      S_DECODE: begin
        op_d   = i_opCode;
        cond_d = i_bCond;
        if (dec_cls == C_ILL) begin
          illegal = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        pc_wr = 1'b1;
        case (cls)
          C_ADD, C_ADDS:   alu_op = ALU_ADD;
          C_SUB, C_SUBS:   alu_op = ALU_SUB;
          C_AND:           alu_op = ALU_AND;
          C_ORR:           alu_op = ALU_ORR;
          C_LSL:           alu_op = ALU_LSL;
          C_LSR:           alu_op = ALU_LSR;
          C_ADDI, C_ADDIS: begin alu_op = ALU_ADD; alu_src_b = 1'b1; end
          C_SUBI, C_SUBIS: begin alu_op = ALU_SUB; alu_src_b = 1'b1; end
          C_ANDI:          begin alu_op = ALU_AND; alu_src_b = 1'b1; end
          C_ORRI:          begin alu_op = ALU_ORR; alu_src_b = 1'b1; end
          C_LDUR:          begin seu = 2'd1; alu_src_b = 1'b1; end
          C_STUR:          begin seu = 2'd1; alu_src_b = 1'b1; reg2_sel = 1'b1; end
          C_B, C_BL:       begin seu = 2'd2; pc_src = 2'd1; end
          C_BR:            pc_src = 2'd2;
          // CBZ/CBNZ route Rt through the ALU so i_aluZ reflects the register under test.
          C_CBZ: begin
            seu      = 2'd3;
            reg2_sel = 1'b1;
            alu_op   = ALU_PASSB;
            pc_src   = i_aluZ ? 2'd1 : 2'd0;
          end
          C_CBNZ: begin
            seu      = 2'd3;
            reg2_sel = 1'b1;
            alu_op   = ALU_PASSB;
            pc_src   = i_aluZ ? 2'd0 : 2'd1;
          end
          C_BCOND: begin
            seu    = 2'd3;
            pc_src = cond_true(nzcv_q, cond_q) ? 2'd1 : 2'd0;
          end
          default: ;
        endcase
        if (sets_flags) nzcv_d = {i_aluN, i_aluZ, i_aluC, i_aluV};
        if ((cls == C_LDUR) || (cls == C_STUR)) state_d = S_MEM;
        else if (is_alu || (cls == C_BL))       state_d = S_WB;
        else                                    state_d = S_FETCH;
      end

      S_MEM: begin
        reg2_sel = (cls == C_STUR);
        if (to_cnt_q == TO_LIMIT) begin
          mem_err  = 1'b1;
          to_cnt_d = '0;
          state_d  = S_FETCH;
        end else begin
          mem_rd = (cls == C_LDUR);
          mem_wr = (cls == C_STUR);
          if (i_memAck) begin
            to_cnt_d = '0;
            state_d  = (cls == C_LDUR) ? S_WB : S_FETCH;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end

      // BL's link value comes from the datapath link mux, which holds the
      // return address captured before EXEC redirected the PC.
      S_WB: begin
        rf_wr       = 1'b1;
        wr_data_sel = (cls != C_LDUR);
        if (cls == C_BL) alu_op = ALU_PASSB;
        state_d     = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_FETCH;
      op_q     <= '0;
      cond_q   <= '0;
      nzcv_q   <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cond_q   <= cond_d;
      nzcv_q   <= nzcv_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Reset forces every strobe low combinationally so an abort takes effect at once.
  assign o_irWr      = ir_wr & ~i_rst;
  assign o_pcWr      = pc_wr & ~i_rst;
  assign o_reg2Sel   = reg2_sel & ~i_rst;
  assign o_rfWr      = rf_wr & ~i_rst;
  assign o_SEU       = i_rst ? 2'd0 : seu;
  assign o_ALUSrcB   = alu_src_b & ~i_rst;
  assign o_ALUOp     = i_rst ? '0 : alu_op;
  assign o_memRd     = mem_rd & ~i_rst;
  assign o_memWr     = mem_wr & ~i_rst;
  assign o_PCSrc     = i_rst ? 2'd0 : pc_src;
  assign o_wrDataSel = wr_data_sel & ~i_rst;
  assign o_flags     = nzcv_q;
  assign o_illegal   = illegal & ~i_rst;
  assign o_memErr    = mem_err & ~i_rst;
  assign o_dbgState  = state_q;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Bench for legv8_multicycle_ctrl: per-cycle expected output vectors are queued
// as each instruction is issued and popped against the DUT at the falling edge.
module tb_legv8_multicycle_ctrl;

  localparam logic [10:0] OP_ADD   = 11'h458;
  localparam logic [10:0] OP_ADDS  = 11'h558;
  localparam logic [10:0] OP_SUBIS = 11'h788;
  localparam logic [10:0] OP_LDUR  = 11'h7C2;
  localparam logic [10:0] OP_STUR  = 11'h7C0;
  localparam logic [10:0] OP_B     = 11'h0A0;
  localparam logic [10:0] OP_BL    = 11'h4A0;
  localparam logic [10:0] OP_BR    = 11'h6B0;
  localparam logic [10:0] OP_CBZ   = 11'h5A0;
  localparam logic [10:0] OP_CBNZ  = 11'h5A8;
  localparam logic [10:0] OP_BCOND = 11'h2A0;

  // Vector: irWr pcWr reg2Sel rfWr SEU[2] ALUSrcB ALUOp[4] memRd memWr PCSrc[2] wrDataSel flags[4] illegal memErr
  localparam logic [21:0] M_ALL = 22'h3FFFFF;
  localparam logic [21:0] M_R2  = ~22'h080000;
  localparam logic [21:0] M_AOP = ~22'h007800;
  localparam logic [21:0] M_SEU = ~22'h030000;

  logic        clk;
  logic        i_rst;
  logic [10:0] i_opCode;
  logic [3:0]  i_bCond;
  logic        i_aluZ, i_aluN, i_aluC, i_aluV, i_memAck;
  logic        o_irWr, o_pcWr, o_reg2Sel, o_rfWr, o_ALUSrcB, o_memRd, o_memWr;
  logic        o_wrDataSel, o_illegal, o_memErr;
  logic [1:0]  o_SEU, o_PCSrc;
  logic [3:0]  o_ALUOp, o_flags;
  logic [2:0]  o_dbgState;
  logic [21:0] obs;

  logic [21:0] exp_q[$];
  logic [21:0] msk_q[$];
  logic [3:0]  flg_exp;
  int          checks;
  int          errors;

  legv8_multicycle_ctrl dut (
    .i_clk(clk), .i_rst(i_rst), .i_opCode(i_opCode), .i_bCond(i_bCond),
    .i_aluZ(i_aluZ), .i_aluN(i_aluN), .i_aluC(i_aluC), .i_aluV(i_aluV),
    .i_memAck(i_memAck), .o_irWr(o_irWr), .o_pcWr(o_pcWr), .o_reg2Sel(o_reg2Sel),
    .o_rfWr(o_rfWr), .o_SEU(o_SEU), .o_ALUSrcB(o_ALUSrcB), .o_ALUOp(o_ALUOp),
    .o_memRd(o_memRd), .o_memWr(o_memWr), .o_PCSrc(o_PCSrc),
    .o_wrDataSel(o_wrDataSel), .o_flags(o_flags), .o_illegal(o_illegal),
    .o_memErr(o_memErr), .o_dbgState(o_dbgState)
  );

  assign obs = {o_irWr, o_pcWr, o_reg2Sel, o_rfWr, o_SEU, o_ALUSrcB, o_ALUOp,
                o_memRd, o_memWr, o_PCSrc, o_wrDataSel, o_flags, o_illegal, o_memErr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [21:0] ev(input logic irw, input logic pcw, input logic r2,
      input logic rfw, input logic [1:0] seu, input logic asb, input logic [3:0] aop,
      input logic mrd, input logic mwr, input logic [1:0] psrc, input logic wds,
      input logic ill, input logic merr);
    return {irw, pcw, r2, rfw, seu, asb, aop, mrd, mwr, psrc, wds, flg_exp, ill, merr};
  endfunction

  function automatic logic [21:0] e_fetch();
    return ev(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [21:0] e_idle();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [21:0] e_exec(input logic r2, input logic [1:0] seu,
      input logic asb, input logic [3:0] aop, input logic [1:0] psrc);
    return ev(1'b0, 1'b1, r2, 1'b0, seu, asb, aop, 1'b0, 1'b0, psrc, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [21:0] e_mem(input logic mrd, input logic mwr, input logic merr);
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, mrd, mwr, 2'd0, 1'b0, 1'b0, merr);
  endfunction

  function automatic logic [21:0] e_wb(input logic wds, input logic [3:0] aop);
    return ev(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, aop, 1'b0, 1'b0, 2'd0, wds, 1'b0, 1'b0);
  endfunction

  // Condition table written as base test + inversion by the code's low bit.
  function automatic logic cond_model(input logic [3:0] f, input logic [3:0] c);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c[0] && (c[3:1] != 3'd7)) r = ~r;
    return r;
  endfunction

  task automatic push(input logic [21:0] e, input logic [21:0] m);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  task automatic test_reset();
    logic [21:0] e, m;
    i_opCode = OP_ADD;
    {i_aluN, i_aluZ, i_aluC, i_aluV} = 4'hF;
    i_memAck = 1'b1;
    flg_exp = 4'h0;
    push(e_idle(), M_ALL);
    push(e_idle(), M_ALL);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL reset c%0d: got %h expected %h", k, obs, e);
      end
      @(posedge clk);
    end
    checks++;
    if (o_dbgState !== 3'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", o_dbgState);
    end
    #1;
    i_rst = 1'b0;
    i_memAck = 1'b0;
    {i_aluN, i_aluZ, i_aluC, i_aluV} = 4'h0;
  endtask

  task automatic test_add();
    logic [21:0] e, m;
    i_opCode = OP_ADD;
    push(e_fetch(), M_ALL);
    push(e_idle(), M_ALL);
    push(e_exec(1'b0, 2'd0, 1'b0, 4'd0, 2'd0), M_ALL);
    push(e_wb(1'b1, 4'd0), M_ALL);
    for (int k = 0; k < 4; k++) begin
      {i_aluN, i_aluZ, i_aluC, i_aluV} = (k == 2) ? 4'hF : 4'h0;
      @(negedge clk);
      e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL add c%0d: got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flags_bcond();
    logic [21:0] e, m;
    logic [3:0]  codes [3];
    logic        takes [3];
    codes = '{4'h0, 4'h1, 4'hA};
    takes = '{1'b1, 1'b0, 1'b1};
    i_opCode = OP_SUBIS;
    push(e_fetch(), M_ALL);
    push(e_idle(), M_ALL);
    push(e_exec(1'b0, 2'd0, 1'b1, 4'd1, 2'd0), M_ALL);
    flg_exp = 4'b0110;
    push(e_wb(1'b1, 4'd0), M_ALL);
    for (int k = 0; k < 4; k++) begin
      {i_aluN, i_aluZ, i_aluC, i_aluV} = (k == 2) ? 4'b0110 : 4'b0000;
      @(negedge clk);
      e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL subis c%0d: got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      i_opCode = OP_BCOND;
      i_bCond  = codes[i];
      push(e_fetch(), M_ALL);
      push(e_idle(), M_ALL);
      push(e_exec(1'b0, 2'd3, 1'b0, 4'd0, {1'b0, takes[i]}), M_AOP);
      for (int k = 0; k < 3; k++) begin
        {i_aluN, i_aluZ, i_aluC, i_aluV} = (k == 2) ? 4'b1001 : 4'b0000;
        @(negedge clk);
        e = exp_q.pop_front(); m = msk_q.pop_front();
        checks++;
        if ((obs & m) !== (e & m)) begin
          errors++;
          $display("FAIL bcond%0d c%0d: got %h expected %h", codes[i], k, obs, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_bcond_random();
    logic [21:0] e, m;
    logic [3:0]  r, c;
    for (int i = 0; i < 6; i++) begin
      r = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      push(e_fetch(), M_ALL);
      push(e_idle(), M_ALL);
      push(e_exec(1'b0, 2'd0, 1'b0, 4'd0, 2'd0), M_ALL);
      flg_exp = r;
      push(e_wb(1'b1, 4'd0), M_ALL);
      push(e_fetch(), M_ALL);
      push(e_idle(), M_ALL);
      push(e_exec(1'b0, 2'd3, 1'b0, 4'd0, {1'b0, cond_model(r, c)}), M_AOP);
      for (int k = 0; k < 7; k++) begin
        i_opCode = (k < 4) ? OP_ADDS : OP_BCOND;
        i_bCond  = c;
        {i_aluN, i_aluZ, i_aluC, i_aluV} = (k == 2) ? r : ~r;
        @(negedge clk);
        e = exp_q.pop_front(); m = msk_q.pop_front();
        checks++;
        if ((obs & m) !== (e & m)) begin
          errors++;
          $display("FAIL rand%0d flags %b cond %0d c%0d: got %h expected %h", i, r, c, k, obs, e);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_ldur();
    logic [21:0] e, m;
    i_opCode = OP_LDUR;
    push(e_fetch(), M_ALL);
    push(e_idle(), M_ALL);
    push(e_exec(1'b0, 2'd1, 1'b1, 4'd0, 2'd0), M_ALL);
    for (int k = 0; k < 3; k++) push(e_mem(1'b1, 1'b0, 1'b0), M_ALL);
    push(e_wb(1'b0, 4'd0), M_ALL);
    for (int k = 0; k < 7; k++) begin
      i_memAck = (k == 5);
      @(negedge clk);
      e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL ldur c%0d: got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
    i_memAck = 1'b0;
  endtask

  task automatic test_stur_timeout();
    logic [21:0] e, m;
    i_opCode = OP_STUR;
    i_memAck = 1'b0;
    push(e_fetch(), M_ALL);
    push(e_idle(), M_ALL);
    push(e_exec(1'b0, 2'd1, 1'b1, 4'd0, 2'd0), M_R2);
    for (int k = 0; k < 15; k++) push(e_mem(1'b0, 1'b1, 1'b0), M_R2);
    push(e_mem(1'b0, 1'b0, 1'b1), M_R2);
    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL stur_to c%0d: got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [21:0] e, m;
    i_opCode = 11'h000;
    push(e_fetch(), M_ALL);
    push(ev(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0), M_ALL);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL illegal c%0d: got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e, m;
    logic [10:0] ops [7];
    logic        zs  [7];
    int          len;
    ops = '{OP_B, OP_BL, OP_BR, OP_CBZ, OP_CBNZ, OP_CBZ, OP_STUR};
    zs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      i_opCode = ops[i];
      push(e_fetch(), M_ALL);
      push(e_idle(), M_ALL);
      len = 3;
      case (i)
        0: push(e_exec(1'b0, 2'd2, 1'b0, 4'd0, 2'd1), M_AOP);
        1: begin
          push(e_exec(1'b0, 2'd2, 1'b0, 4'd0, 2'd1), M_AOP);
          push(e_wb(1'b1, 4'd8), M_ALL);
          len = 4;
        end
        2: push(e_exec(1'b0, 2'd0, 1'b0, 4'd0, 2'd2), M_AOP & M_SEU);
        3: push(e_exec(1'b0, 2'd3, 1'b0, 4'd0, 2'd1), M_AOP & M_R2);
        4: push(e_exec(1'b0, 2'd3, 1'b0, 4'd0, 2'd0), M_AOP & M_R2);
        5: push(e_exec(1'b0, 2'd3, 1'b0, 4'd0, 2'd0), M_AOP & M_R2);
        default: begin
          push(e_exec(1'b0, 2'd1, 1'b1, 4'd0, 2'd0), M_R2);
          push(e_mem(1'b0, 1'b1, 1'b0), M_R2);
          len = 4;
        end
      endcase
      for (int k = 0; k < len; k++) begin
        i_aluZ   = (k == 2) ? zs[i] : ~zs[i];
        i_memAck = (k == 3);
        @(negedge clk);
        e = exp_q.pop_front(); m = msk_q.pop_front();
        checks++;
        if ((obs & m) !== (e & m)) begin
          errors++;
          $display("FAIL b2b op%0d c%0d: got %h expected %h", i, k, obs, e);
        end
        @(posedge clk); #1;
      end
    end
    i_memAck = 1'b0;
    i_aluZ   = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [21:0] e, m;
    push(e_fetch(), M_ALL);
    push(e_idle(), M_ALL);
    push(e_exec(1'b0, 2'd0, 1'b0, 4'd0, 2'd0), M_ALL);
    flg_exp = 4'b1010;
    push(e_wb(1'b1, 4'd0), M_ALL);
    push(e_fetch(), M_ALL);
    push(e_idle(), M_ALL);
    push(e_exec(1'b0, 2'd1, 1'b1, 4'd0, 2'd0), M_ALL);
    push(e_mem(1'b1, 1'b0, 1'b0), M_ALL);
    for (int k = 0; k < 8; k++) begin
      i_opCode = (k < 4) ? OP_ADDS : OP_LDUR;
      {i_aluN, i_aluZ, i_aluC, i_aluV} = (k == 2) ? 4'b1010 : 4'b0000;
      @(negedge clk);
      e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL rstmid_pre c%0d: got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
    #2;
    i_rst = 1'b1;
    #1;
    flg_exp = 4'h0;
    push(e_idle(), M_ALL);
    push(e_idle(), M_ALL);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) @(negedge clk);
      e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL rstmid_hold c%0d: got %h expected %h", k, obs, e);
      end
    end
    @(posedge clk); #1;
    i_rst = 1'b0;
    push(e_fetch(), M_ALL);
    push(e_idle(), M_ALL);
    push(e_exec(1'b0, 2'd1, 1'b1, 4'd0, 2'd0), M_ALL);
    push(e_mem(1'b1, 1'b0, 1'b0), M_ALL);
    push(e_wb(1'b0, 4'd0), M_ALL);
    for (int k = 0; k < 5; k++) begin
      i_memAck = (k == 3);
      @(negedge clk);
      e = exp_q.pop_front(); m = msk_q.pop_front();
      checks++;
      if ((obs & m) !== (e & m)) begin
        errors++;
        $display("FAIL rstmid_post c%0d: got %h expected %h", k, obs, e);
      end
      @(posedge clk); #1;
    end
    i_memAck = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    flg_exp  = 4'h0;
    i_rst    = 1'b1;
    i_opCode = 11'h000;
    i_bCond  = 4'h0;
    i_memAck = 1'b0;
    {i_aluN, i_aluZ, i_aluC, i_aluV} = 4'h0;
    test_reset();
    test_add();
    test_flags_bcond();
    test_bcond_random();
    test_ldur();
    test_stur_timeout();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
